// File: rtl/gated_reg_arbiter.sv
// Round-robin arbiter driving a shared enable-gated output register.
// Optional hold timeout: define GATED_REG_ARB_TIMEOUT_EN to force release after MAX_HOLD captures.
module gated_reg_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*DW-1:0]       data_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic [DW-1:0]             out_o,
   output logic                      out_valid_o,
   output logic [$clog2(N_REQ)-1:0]  owner_o
);
   localparam int IW = $clog2(N_REQ);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [DW-1:0]    out_q, out_d;
   logic             vld_q, vld_d;
   logic [IW-1:0]    nxt;
   logic [IW-1:0]    win;
   logic             release_now;
`ifdef GATED_REG_ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0]    hold_q, hold_d;
`endif

   // First set bit at or above start, wrapping at N_REQ (not at 2**IW).
   function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IW-1:0]    start);
      logic [IW-1:0] pick;
      logic          found;
      int            idx;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(start) + k) % N_REQ;
         if (!found && r[idx]) begin
            pick  = IW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign nxt = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      gnt_d       = gnt_q;
      out_d       = out_q;
      vld_d       = 1'b0;
      win         = '0;
      release_now = 1'b0;
`ifdef GATED_REG_ARB_TIMEOUT_EN
      hold_d      = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               win          = rr_pick(req_i, ptr_q);
               gnt_d        = '0;
               gnt_d[win]   = 1'b1;
               owner_d      = win;
               state_d      = BUSY;
`ifdef GATED_REG_ARB_TIMEOUT_EN
               hold_d       = '0;
`endif
            end
         end
         BUSY: begin
            if (req_i[owner_q]) begin
               out_d = data_i[int'(owner_q)*DW +: DW];
               vld_d = 1'b1;
`ifdef GATED_REG_ARB_TIMEOUT_EN
               hold_d = hold_q + 1'b1;
               if (hold_q + 1'b1 == HW'(MAX_HOLD)) release_now = 1'b1;
`endif
            end else begin
               release_now = 1'b1;
            end
            // Scanning from owner+1 makes the old owner the last candidate.
            if (release_now) begin
               ptr_d = nxt;
               if (|req_i) begin
                  win        = rr_pick(req_i, nxt);
                  gnt_d      = '0;
                  gnt_d[win] = 1'b1;
                  owner_d    = win;
`ifdef GATED_REG_ARB_TIMEOUT_EN
                  hold_d     = '0;
`endif
               end else begin
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
`ifdef GATED_REG_ARB_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
`ifdef GATED_REG_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign gnt_o       = gnt_q;
   assign out_o       = out_q;
   assign out_valid_o = vld_q;
   assign owner_o     = owner_q;

endmodule

// File: doc/gated_reg_arbiter.md
# gated_reg_arbiter

Round-robin arbiter and sequencer for a shared enable-gated output register. Up to `N_REQ` requesters compete for the register. The block issues a one-hot grant and drives the register's enable from the winner's request. It captures the winner's data into `out` on every cycle the grant is held. It sits in front of the enable/data flop used in the synthesis test benches and replaces ad-hoc enable muxing.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DW`, 8, data width
- `MAX_HOLD`, 8, maximum consecutive captures per grant (only used with the timeout macro; ≥1)
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  N_REQ  request vector, one bit per requester
- `data`  in  N_REQ*DW  requester data; requester i occupies bits [i*DW +: DW]
- `gnt`  out  N_REQ  one-hot grant (all-zero when idle), registered
- `out`  out  DW  shared gated register
- `out_valid`  out  1  high for the one cycle after an edge on which `out` was loaded
- `owner`  out  $clog2(N_REQ)  index of the current grant holder; valid when `gnt` != 0

## Operation
- Reset values:
  - `gnt`=0, `out`=0, `out_valid`=0, `owner`=0.
  - Internal: state=IDLE, RR pointer `ptr`=0, `hold_cnt`=0.
- States: IDLE, BUSY.
- IDLE, edge with any `req` set:
  - The winner w is the first set `req` bit scanning upward from `ptr` with wrap.
  - `gnt`<=onehot(w), `owner`<=w, `hold_cnt`<=0, state goes to BUSY.
  - No capture on this edge.
- IDLE, edge with `req`=0: no change.
- BUSY with owner g, edge with `req[g]`=1 (capture):
  - `out`<=data[g], `out_valid`<=1, `hold_cnt`<=hold_cnt+1.
- BUSY with owner g, edge with `req[g]`=0 (release):
  - No capture; `out` holds its value.
  - `ptr`<=(g+1) mod N_REQ.
  - If any other `req` bit is set, choose a new winner by scanning from g+1. Set `gnt`/`owner` directly with no idle cycle, `hold_cnt`<=0, and stay in BUSY.
  - Otherwise `gnt`<=0 and state goes to IDLE.
- `out_valid` is 0 on every edge without a capture.
- Round-robin fairness: a released owner has the lowest priority on its release edge.
- The `data` bits of non-owners are ignored.

## Timing
- Request to grant: 1 edge.
- Grant to first capture: 1 edge. A requester whose `req` is set at cycle t therefore sees `out` loaded at edge t+2 at the earliest.
- Capture to `out_valid`: `out` and `out_valid` update on the same edge.
- Handover between owners: one edge with no capture. The new `gnt` appears on the release edge.
- Simultaneous requests: resolved only through `ptr`; requesters that raise `req` together are granted in order upward from `ptr`.
- `req` dropping and rising again on the same owner within one cycle does not exist at edge granularity. Only the sampled value counts.
- Asynchronous `rst` mid-grant: all outputs clear immediately. The first grant after deassertion follows the IDLE rule with `ptr`=0.
- `N_REQ` not a power of two: `ptr` and the winner scan wrap at `N_REQ`. Indices ≥ N_REQ are never granted.

## Configuration
- `GATED_REG_ARB_TIMEOUT_EN`:
  - Defined: when a capture makes `hold_cnt` reach `MAX_HOLD`, that same edge is a forced release even though `req[g]`=1.
    - `ptr`<=g+1, and a new winner is scanned from g+1.
    - g is eligible only if no other `req` is set. In that case g is re-granted with `hold_cnt`<=0, `gnt` is unchanged, and the next edge captures normally.
  - Not defined: `MAX_HOLD` is unused, `hold_cnt` is unused, and the grant is held as long as `req[g]`=1.

## Test plan
- Reset then single request: `req`=4'b0010, `data[1]`=8'hA5.
  - `gnt`=0010 after edge 1; `out`=A5 and `out_valid`=1 after edge 2.
  - Async `rst` in the middle of the transfer clears `gnt`, `out` and `out_valid` without waiting for a clock edge.
- Simultaneous `req`=4'b1011 from reset, each requester dropping `req` after 2 captures.
  - Grant order is 0, 1, 3, with a one-edge gap (no capture) at each handover.
  - `ptr` ends at 0.
- Fairness: requester 0 re-raises `req` on its release edge while requester 2 is requesting.
  - Grant goes to 2 before 0.
- Idle return: owner drops `req` with no others pending.
  - `gnt`=0 on the next edge; `out` holds its last value; `out_valid`=0.
- Timeout (macro defined, `MAX_HOLD`=3): `req[0]` and `req[1]` held high continuously.
  - Grant alternates 0, 1, 0 every 3 captures.
  - With only `req[0]` high, `gnt` stays 0001 and captures are continuous.
- Timeout macro undefined: same stimulus as the timeout scenario.
  - Requester 0 keeps the grant indefinitely; requester 1 is never granted.
